// File: rtl/sample_stim_check_if.sv
// Bundle of the run-control, stimulus, response and result signals of sample_stim_check.
// Latency: none (wires only).
// Backpressure: none; every signal is a plain level, sampled on core clock edges.
//
// slave  : the checker side (drives stimulus and results, receives start and responses).
// master : the controller/netlist side (drives start and responses, receives the rest).
interface sample_stim_check_if #(
    parameter int unsigned ERR_CNT_W = 16
) ();
    logic                 start;
    logic                 drive_a;
    logic                 drive_b;
    logic                 obs_a_inv1;
    logic                 obs_a_inv2;
    logic                 obs_b_inv1;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [ERR_CNT_W-1:0] err_count;
    logic [15:0]          first_err_idx;
    logic [2:0]           first_err_vec;

    modport slave (
        input  start, obs_a_inv1, obs_a_inv2, obs_b_inv1,
        output drive_a, drive_b, busy, done, pass, err_count, first_err_idx, first_err_vec
    );

    modport master (
        output start, obs_a_inv1, obs_a_inv2, obs_b_inv1,
        input  drive_a, drive_b, busy, done, pass, err_count, first_err_idx, first_err_vec
    );
endinterface

// File: rtl/sample_stim_check.sv
// LFSR stimulus generator and one-cycle-delayed golden checker for the two-flop sample netlist.
// Latency: start-to-done is NUM_VECTORS+2 cycles; each vector is checked the cycle after it is driven.
// Backpressure: none; start is ignored while busy, results hold in DONE until start or rst.
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset, priority over start
//   bus  - sample_stim_check_if.slave: start / obs_* in; drive_a/b, busy, done, pass,
//          err_count, first_err_idx, first_err_vec out (all registered)
// Optional: define SAMPLE_CHK_FIRST_FAIL_EN to capture index and mismatch mask of the
// first failing vector; otherwise first_err_idx/first_err_vec are tied to 0.
module sample_stim_check #(
    parameter int unsigned NUM_VECTORS = 1024,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter logic [15:0] TAPS        = 16'hB400,
    parameter int unsigned ERR_CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    sample_stim_check_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [15:0]          LP_SEED    = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0]          LP_LAST    = 16'(NUM_VECTORS - 1);
    localparam logic [ERR_CNT_W-1:0] LP_ERR_MAX = {ERR_CNT_W{1'b1}};

    state_t               r_state;
    state_t               w_state_nxt;

    logic [15:0]          r_lfsr;        // holds the vector currently on drive_a/drive_b
    logic [15:0]          r_vec_idx;     // index of the vector currently driven
    logic                 r_drive_a;
    logic                 r_drive_b;
    logic                 r_exp_a;       // golden pipeline: previous cycle's drive
    logic                 r_exp_b;
    logic                 r_chk_vld;     // previous cycle was a RUN cycle
    logic                 r_busy;
    logic                 r_done;
    logic                 r_pass;
    logic [ERR_CNT_W-1:0] r_err_count;

    logic                 w_start_ok;
    logic                 w_last;
    logic [15:0]          w_lfsr_adv;
    logic [2:0]           w_obs_vec;
    logic [2:0]           w_exp_vec;
    logic [2:0]           w_mis_vec;
    logic                 w_mis;
    logic [ERR_CNT_W-1:0] w_err_nxt;

    assign w_start_ok = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last     = (r_vec_idx == LP_LAST);
    assign w_lfsr_adv = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : 16'h0000);

    // Mask order {b_inv1, a_inv2, a_inv1}; the expected pattern follows the netlist's
    // one-flop delay with the named inversions.
    assign w_obs_vec  = {bus.obs_b_inv1, bus.obs_a_inv2, bus.obs_a_inv1};
    assign w_exp_vec  = {~r_exp_b, ~r_exp_a, r_exp_a};
    assign w_mis_vec  = w_obs_vec ^ w_exp_vec;
    assign w_mis      = r_chk_vld && (w_mis_vec != 3'b000);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last)    w_state_nxt = S_DRAIN;
            S_DRAIN:                w_state_nxt = S_DONE;
            S_DONE:  if (bus.start) w_state_nxt = S_RUN;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    // Saturating error count including this cycle's check.
    always_comb begin
        w_err_nxt = r_err_count;
        if (w_mis && (r_err_count != LP_ERR_MAX)) begin
            w_err_nxt = r_err_count + ERR_CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus, golden pipeline and results
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr      <= 16'h0000;
            r_vec_idx   <= 16'h0000;
            r_drive_a   <= 1'b0;
            r_drive_b   <= 1'b0;
            r_exp_a     <= 1'b0;
            r_exp_b     <= 1'b0;
            r_chk_vld   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_exp_a   <= r_drive_a;
            r_exp_b   <= r_drive_b;
            r_chk_vld <= (r_state == S_RUN);
            r_busy    <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
            r_done    <= (w_state_nxt == S_DONE);

            if (w_start_ok) begin
                r_lfsr      <= LP_SEED;
                r_drive_a   <= LP_SEED[0];
                r_drive_b   <= LP_SEED[1];
                r_vec_idx   <= 16'h0000;
                r_err_count <= '0;
                r_pass      <= 1'b0;
            end else begin
                r_err_count <= w_err_nxt;
                case (r_state)
                    S_RUN: begin
                        if (w_last) begin
                            r_drive_a <= 1'b0;
                            r_drive_b <= 1'b0;
                        end else begin
                            r_lfsr    <= w_lfsr_adv;
                            r_drive_a <= w_lfsr_adv[0];
                            r_drive_b <= w_lfsr_adv[1];
                            r_vec_idx <= r_vec_idx + 16'd1;
                        end
                    end
                    // The last vector's check lands in DRAIN, so pass must see it.
                    S_DRAIN: r_pass <= (w_err_nxt == '0);
                    default: ;
                endcase
            end
        end
    end

`ifdef SAMPLE_CHK_FIRST_FAIL_EN
    logic [15:0] r_exp_idx;        // index of the vector under check this cycle
    logic [15:0] r_first_err_idx;
    logic [2:0]  r_first_err_vec;
    logic        r_first_seen;     // freezes the capture for the rest of the run

    always_ff @(posedge clk) begin
        if (rst) begin
            r_exp_idx       <= 16'h0000;
            r_first_err_idx <= 16'h0000;
            r_first_err_vec <= 3'b000;
            r_first_seen    <= 1'b0;
        end else begin
            r_exp_idx <= r_vec_idx;
            if (w_start_ok) begin
                r_first_err_idx <= 16'h0000;
                r_first_err_vec <= 3'b000;
                r_first_seen    <= 1'b0;
            end else if (w_mis && !r_first_seen) begin
                r_first_err_idx <= r_exp_idx;
                r_first_err_vec <= w_mis_vec;
                r_first_seen    <= 1'b1;
            end
        end
    end

    assign bus.first_err_idx = r_first_err_idx;
    assign bus.first_err_vec = r_first_err_vec;
`else
    assign bus.first_err_idx = 16'h0000;
    assign bus.first_err_vec = 3'b000;
`endif

    assign bus.drive_a   = r_drive_a;
    assign bus.drive_b   = r_drive_b;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.err_count = r_err_count;

endmodule

// File: tb/tb_sample_stim_check.sv
module tb_sample_stim_check;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    sample_stim_check_if #(.ERR_CNT_W(16)) if0 ();
    sample_stim_check_if #(.ERR_CNT_W(2))  if1 ();
    sample_stim_check_if #(.ERR_CNT_W(16)) if2 ();
    sample_stim_check_if #(.ERR_CNT_W(16)) if3 ();

    sample_stim_check #(.NUM_VECTORS(8), .ERR_CNT_W(16)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    sample_stim_check #(.NUM_VECTORS(64), .ERR_CNT_W(2)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    sample_stim_check #(.NUM_VECTORS(16), .ERR_CNT_W(16)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
    sample_stim_check #(.NUM_VECTORS(8), .SEED(16'h0000), .ERR_CNT_W(16)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));

    // Behavioural two-flop sample netlists, one per checker, with fault injection on #0.
    logic       qa0, qb0, qa1, qb1, qa2, qb2, qa3, qb3;
    logic [2:0] inj0;
    always @(posedge clk) begin
        qa0 <= if0.drive_a; qb0 <= if0.drive_b;
        qa1 <= if1.drive_a; qb1 <= if1.drive_b;
        qa2 <= if2.drive_a; qb2 <= if2.drive_b;
        qa3 <= if3.drive_a; qb3 <= if3.drive_b;
    end
    assign if0.obs_a_inv1 = qa0 ^ inj0[0];
    assign if0.obs_a_inv2 = ~qa0 ^ inj0[1];
    assign if0.obs_b_inv1 = ~qb0 ^ inj0[2];
    assign if1.obs_a_inv1 = 1'b0;            // stuck-at-0 fault
    assign if1.obs_a_inv2 = ~qa1;
    assign if1.obs_b_inv1 = ~qb1;
    assign if2.obs_a_inv1 = qa2;
    assign if2.obs_a_inv2 = ~qa2;
    assign if2.obs_b_inv1 = ~qb2;
    assign if3.obs_a_inv1 = qa3;
    assign if3.obs_a_inv2 = ~qa3;
    assign if3.obs_b_inv1 = ~qb3;

    logic [2:0] fmask0 [0:7];
    logic [2:0] premask0;
    logic [1:0] seq2 [0:15];

    // Reference: {a,b} of vector k from the seed and the Galois right-shift rule.
    function automatic logic [1:0] ref_ab(input logic [15:0] seed, input int k);
        logic [15:0] s;
        s = (seed == 16'h0000) ? 16'h0001 : seed;
        for (int i = 0; i < k; i++) s = (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
        return {s[0], s[1]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({if0.busy, if0.done, if0.pass, if0.drive_a, if0.drive_b} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000",
                     {if0.busy, if0.done, if0.pass, if0.drive_a, if0.drive_b});
        end
        checks++;
        if (if0.err_count !== 16'd0) begin
            errors++; $display("FAIL reset_err_count got %0d want 0", if0.err_count);
        end
        checks++;
        if (if0.first_err_idx !== 16'd0 || if0.first_err_vec !== 3'd0) begin
            errors++; $display("FAIL reset_first_err got %0d/%b want 0/000", if0.first_err_idx, if0.first_err_vec);
        end
        rst = 1'b0;
        tick();
    endtask

    // One run of checker #0 with per-vector fault masks; checks timing, drives and results.
    task automatic run0(input string tag);
        int         nerr;
        int         fidx;
        logic [2:0] fvec;
        logic [1:0] ab;
        nerr = 0; fidx = -1; fvec = 3'b000;
        @(negedge clk); if0.start = 1'b1;
        @(posedge clk); #1; if0.start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            inj0 = (c == 1) ? premask0 : fmask0[c-2];
            checks++;
            if (if0.busy !== 1'b1 || if0.done !== 1'b0) begin
                errors++; $display("FAIL %s busy_cycle%0d got busy=%b done=%b want 1/0", tag, c, if0.busy, if0.done);
            end
            ab = (c <= 8) ? ref_ab(16'hACE1, c - 1) : 2'b00;
            checks++;
            if ({if0.drive_a, if0.drive_b} !== ab) begin
                errors++; $display("FAIL %s drive_cycle%0d got %b want %b", tag, c, {if0.drive_a, if0.drive_b}, ab);
            end
            tick();
        end
        inj0 = 3'b000;
        for (int k = 0; k < 8; k++) begin
            if (fmask0[k] != 3'b000) begin
                nerr++;
                if (fidx < 0) begin fidx = k; fvec = fmask0[k]; end
            end
        end
`ifndef SAMPLE_CHK_FIRST_FAIL_EN
        fidx = -1; fvec = 3'b000;
`endif
        if (fidx < 0) fidx = 0;
        checks++;
        if (if0.done !== 1'b1 || if0.busy !== 1'b0) begin
            errors++; $display("FAIL %s done_cycle10 got done=%b busy=%b want 1/0", tag, if0.done, if0.busy);
        end
        checks++;
        if (if0.err_count !== 16'(nerr)) begin
            errors++; $display("FAIL %s err_count got %0d want %0d", tag, if0.err_count, nerr);
        end
        checks++;
        if (if0.pass !== (nerr == 0)) begin
            errors++; $display("FAIL %s pass got %b want %b", tag, if0.pass, (nerr == 0));
        end
        checks++;
        if (if0.first_err_idx !== 16'(fidx) || if0.first_err_vec !== fvec) begin
            errors++; $display("FAIL %s first_err got %0d/%b want %0d/%b", tag,
                               if0.first_err_idx, if0.first_err_vec, fidx, fvec);
        end
        repeat (3) tick();
        checks++;
        if (if0.done !== 1'b1 || if0.err_count !== 16'(nerr)) begin
            errors++; $display("FAIL %s done_hold got done=%b err=%0d want 1/%0d", tag, if0.done, if0.err_count, nerr);
        end
    endtask

    task automatic test_clean_run;
        for (int k = 0; k < 8; k++) fmask0[k] = 3'b000;
        premask0 = 3'b111;   // garbage during the first RUN cycle must never be checked
        run0("clean");
    endtask

    task automatic test_single_fault;
        for (int k = 0; k < 8; k++) fmask0[k] = 3'b000;
        fmask0[3] = 3'b010;
        premask0  = 3'b000;
        run0("a_inv2_v3");
    endtask

    task automatic test_random_faults;
        for (int it = 0; it < 4; it++) begin
            for (int k = 0; k < 8; k++)
                fmask0[k] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            premask0 = 3'($urandom_range(0, 7));
            run0($sformatf("random%0d", it));
        end
    endtask

    task automatic test_saturation;
        int  ones;
        int  prev;
        int  done_at;
        bit  wrapped;
        ones = 0; prev = 0; done_at = -1; wrapped = 0;
        for (int k = 0; k < 64; k++) if (ref_ab(16'hACE1, k) & 2'b10) ones++;
        if (ones > 3) ones = 3;
        @(negedge clk); if1.start = 1'b1;
        @(posedge clk); #1; if1.start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (int'(if1.err_count) < prev) wrapped = 1;
            prev = int'(if1.err_count);
            if (if1.done) begin done_at = c; break; end
            tick();
        end
        checks++;
        if (done_at != 66) begin
            errors++; $display("FAIL sat_done_cycle got %0d want 66", done_at);
        end
        checks++;
        if (if1.err_count !== 2'(ones)) begin
            errors++; $display("FAIL sat_err_count got %0d want %0d", if1.err_count, ones);
        end
        checks++;
        if (wrapped) begin
            errors++; $display("FAIL sat_wrap got wrapped want monotonic");
        end
        checks++;
        if (if1.pass !== 1'b0) begin
            errors++; $display("FAIL sat_pass got %b want 0", if1.pass);
        end
    endtask

    // One run of checker #2: optional reset at cycle rst_at, optional start pulses.
    task automatic run2(input int rst_at, input int pulse_a, input int pulse_b, output int done_at);
        done_at = -1;
        @(negedge clk); if2.start = 1'b1;
        @(posedge clk); #1; if2.start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c <= 16) seq2[c-1] = {if2.drive_a, if2.drive_b};
            if (if2.done) begin done_at = c; break; end
            if2.start = (c == pulse_a) || (c == pulse_b);
            rst       = (c == rst_at);
            tick();
            if2.start = 1'b0;
            rst       = 1'b0;
            if (c == rst_at) break;
        end
    endtask

    task automatic check_seq2(input string tag);
        int bad;
        bad = -1;
        for (int k = 15; k >= 0; k--) if (seq2[k] !== ref_ab(16'hACE1, k)) bad = k;
        checks++;
        if (bad >= 0) begin
            errors++; $display("FAIL %s drive_seq vector %0d got %b want %b", tag, bad, seq2[bad], ref_ab(16'hACE1, bad));
        end
    endtask

    task automatic test_reset_midrun;
        int         d;
        logic [1:0] first5 [0:4];
        run2(5, 0, 0, d);
        for (int k = 0; k < 5; k++) first5[k] = seq2[k];
        checks++;
        if ({if2.busy, if2.done, if2.pass, if2.drive_a, if2.drive_b} !== 5'b0 ||
            if2.err_count !== 16'd0 || if2.first_err_idx !== 16'd0 || if2.first_err_vec !== 3'd0) begin
            errors++; $display("FAIL rst_mid_outputs got busy=%b done=%b pass=%b a=%b b=%b err=%0d want all 0",
                               if2.busy, if2.done, if2.pass, if2.drive_a, if2.drive_b, if2.err_count);
        end
        run2(0, 0, 0, d);
        checks++;
        if (d != 18) begin
            errors++; $display("FAIL rst_mid_restart_done got cycle %0d want 18", d);
        end
        check_seq2("rst_mid_restart");
        checks++;
        if (seq2[0] !== first5[0] || seq2[1] !== first5[1] || seq2[2] !== first5[2] ||
            seq2[3] !== first5[3] || seq2[4] !== first5[4]) begin
            errors++; $display("FAIL rst_mid_same_prefix got %b%b%b%b%b want %b%b%b%b%b",
                               seq2[0], seq2[1], seq2[2], seq2[3], seq2[4],
                               first5[0], first5[1], first5[2], first5[3], first5[4]);
        end
        checks++;
        if (if2.pass !== 1'b1 || if2.err_count !== 16'd0) begin
            errors++; $display("FAIL rst_mid_pass got pass=%b err=%0d want 1/0", if2.pass, if2.err_count);
        end
    endtask

    task automatic test_start_ignored_and_restart;
        int d;
        run2(0, $urandom_range(1, 16), 17, d);   // restart from DONE, pulses in RUN and DRAIN
        checks++;
        if (d != 18) begin
            errors++; $display("FAIL start_ignored_done got cycle %0d want 18", d);
        end
        checks++;
        if (seq2[0] !== 2'b10) begin
            errors++; $display("FAIL restart_first_vector got %b want 10", seq2[0]);
        end
        check_seq2("start_ignored");
        checks++;
        if (if2.pass !== 1'b1 || if2.err_count !== 16'd0) begin
            errors++; $display("FAIL start_ignored_pass got pass=%b err=%0d want 1/0", if2.pass, if2.err_count);
        end
    endtask

    task automatic test_seed_zero;
        int         done_at;
        int         bad;
        bit         varies;
        logic [1:0] s [0:7];
        done_at = -1; bad = -1; varies = 0;
        @(negedge clk); if3.start = 1'b1;
        @(posedge clk); #1; if3.start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c <= 8) s[c-1] = {if3.drive_a, if3.drive_b};
            if (if3.done) begin done_at = c; break; end
            tick();
        end
        for (int k = 7; k >= 0; k--) begin
            if (s[k] !== ref_ab(16'h0000, k)) bad = k;
            if (s[k] !== s[0]) varies = 1;
        end
        checks++;
        if (done_at != 10) begin
            errors++; $display("FAIL seed0_done got cycle %0d want 10", done_at);
        end
        checks++;
        if (s[0] !== 2'b10) begin
            errors++; $display("FAIL seed0_first_vector got %b want 10", s[0]);
        end
        checks++;
        if (bad >= 0) begin
            errors++; $display("FAIL seed0_seq vector %0d got %b want %b", bad, s[bad], ref_ab(16'h0000, bad));
        end
        checks++;
        if (!varies) begin
            errors++; $display("FAIL seed0_nonconstant got constant %b want varying", s[0]);
        end
        checks++;
        if (if3.pass !== 1'b1) begin
            errors++; $display("FAIL seed0_pass got %b want 1", if3.pass);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        if0.start = 1'b0; if1.start = 1'b0; if2.start = 1'b0; if3.start = 1'b0;
        inj0 = 3'b000;
        premask0 = 3'b000;
        for (int k = 0; k < 8; k++) fmask0[k] = 3'b000;
        test_reset();
        test_clean_run();
        test_single_fault();
        test_random_faults();
        test_saturation();
        test_reset_midrun();
        test_start_ignored_and_restart();
        test_seed_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
